// File: rtl/fog_err_demod_if.sv
`default_nettype none
// fog_err_demod_if: ADC sample stream, loop configuration and step/trigger outputs of the FOG demodulator.
interface fog_err_demod_if #(
  parameter int ADC_WIDTH = 14,
  parameter int ERR_WIDTH = 32
);
  logic                        i_adc_valid;
  logic signed [ADC_WIDTH-1:0] i_adc;
  logic        [31:0]          i_freq;
  logic        [31:0]          i_wait_cnt;
  logic signed [31:0]          i_err_offset;
  logic                        i_polarity;
  logic        [31:0]          i_fb_ON;
  logic        [31:0]          i_gain_sel;
  logic                        o_mod_sign;
  logic signed [ERR_WIDTH-1:0] o_err;
  logic signed [ERR_WIDTH-1:0] o_step;
  logic                        o_trig;
  logic        [1:0]           o_status;

  modport master (
    output i_adc_valid, i_adc, i_freq, i_wait_cnt, i_err_offset, i_polarity, i_fb_ON, i_gain_sel,
    input  o_mod_sign, o_err, o_step, o_trig, o_status
  );

  modport slave (
    input  i_adc_valid, i_adc, i_freq, i_wait_cnt, i_err_offset, i_polarity, i_fb_ON, i_gain_sel,
    output o_mod_sign, o_err, o_step, o_trig, o_status
  );
endinterface
`default_nettype wire

// File: rtl/fog_err_demod.sv
`default_nettype none
// fog_err_demod: square-wave modulation, per-half ADC integration and once-per-period
// saturating error / scaled step output with a one-cycle trigger.
module fog_err_demod #(
  parameter int ADC_WIDTH = 14,
  parameter int ERR_WIDTH = 32
) (
  input  wire logic      i_clk,
  input  wire logic      i_rst_n,
  fog_err_demod_if.slave bus
);
  localparam int DW = ((ERR_WIDTH > 32) ? ERR_WIDTH : 32) + 2;
  localparam logic [0:0] S_NEG = 1'b0;
  localparam logic [0:0] S_POS = 1'b1;
  localparam logic signed [ERR_WIDTH-1:0] E_MAX = {1'b0, {(ERR_WIDTH-1){1'b1}}};
  localparam logic signed [ERR_WIDTH-1:0] E_MIN = {1'b1, {(ERR_WIDTH-1){1'b0}}};
  localparam logic signed [DW-1:0] D_MAX = {{(DW-ERR_WIDTH+1){1'b0}}, {(ERR_WIDTH-1){1'b1}}};
  localparam logic signed [DW-1:0] D_MIN = {{(DW-ERR_WIDTH+1){1'b1}}, {(ERR_WIDTH-1){1'b0}}};

  logic [0:0] state, state_next;
  logic       mod_sign;
  logic [1:0] status;

  logic [31:0]        cnt;
  logic [31:0]        freq_sh, wait_sh;
  logic signed [31:0] offset_sh;
  logic               pol_sh;
  logic [4:0]         gain_sh;
  logic [31:0]        freq_in;
  logic [4:0]         gain_in;

  logic fb_on, active, fresh, sat_flag;
  logic pend, pend_sat, sat_hold, trig_q;
  logic [4:0] gain_p;
  logic signed [ERR_WIDTH-1:0] acc_pos, acc_neg, err_q, step_q;

  logic last, period_end, run, add, add_sat;
  logic signed [ERR_WIDTH:0]   sum_wide;
  logic signed [ERR_WIDTH-1:0] acc_cur, sum_sat, neg_fin, err_mag, err_calc;
  logic signed [DW-1:0]        diff;

  // Modulation state machine: one toggle per completed half-period.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_POS;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (last) state_next = (state == S_POS) ? S_NEG : S_POS;
  end

  always_comb begin
    mod_sign = (state == S_POS);
    status   = 2'd0;
    if (fb_on && active) status = sat_hold ? 2'd3 : (mod_sign ? 2'd1 : 2'd2);
  end

  always_comb begin
    freq_in = (bus.i_freq < 32'd2) ? 32'd2 : bus.i_freq;
    gain_in = (bus.i_gain_sel > 32'd31) ? 5'd31 : bus.i_gain_sel[4:0];
  end

  // The period-closing sample is folded into the error combinationally, so the
  // accumulators are free for the very next sample.
  always_comb begin
    last       = bus.i_adc_valid && (cnt == freq_sh - 32'd1);
    period_end = last && (state == S_NEG);
    run        = fb_on && (active || fresh);
    add        = bus.i_adc_valid && run && (cnt >= wait_sh);
    acc_cur    = (state == S_POS) ? acc_pos : acc_neg;
    sum_wide   = {acc_cur[ERR_WIDTH-1], acc_cur}
               + {{(ERR_WIDTH+1-ADC_WIDTH){bus.i_adc[ADC_WIDTH-1]}}, bus.i_adc};
    add_sat    = add && (sum_wide[ERR_WIDTH] != sum_wide[ERR_WIDTH-1]);
    if (sum_wide[ERR_WIDTH] != sum_wide[ERR_WIDTH-1])
      sum_sat = sum_wide[ERR_WIDTH] ? E_MIN : E_MAX;
    else
      sum_sat = sum_wide[ERR_WIDTH-1:0];
    neg_fin = add ? sum_sat : acc_neg;
    diff    = {{(DW-ERR_WIDTH){acc_pos[ERR_WIDTH-1]}}, acc_pos}
            - {{(DW-ERR_WIDTH){neg_fin[ERR_WIDTH-1]}}, neg_fin}
            - {{(DW-32){offset_sh[31]}}, offset_sh};
    if (diff > D_MAX)      err_mag = E_MAX;
    else if (diff < D_MIN) err_mag = E_MIN;
    else                   err_mag = diff[ERR_WIDTH-1:0];
    if (!pol_sh)               err_calc = err_mag;
    else if (err_mag == E_MIN) err_calc = E_MAX;
    else                       err_calc = -err_mag;
  end

  // Plain pipeline register; it keeps sampling through reset so a loop that is
  // closed while reset is held runs its first period.
  always_ff @(posedge i_clk) begin
    fb_on <= (bus.i_fb_ON != 32'd0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt       <= 32'd0;
      acc_pos   <= '0;
      acc_neg   <= '0;
      sat_flag  <= 1'b0;
      active    <= 1'b0;
      fresh     <= 1'b1;
      pend      <= 1'b0;
      pend_sat  <= 1'b0;
      gain_p    <= 5'd0;
      sat_hold  <= 1'b0;
      err_q     <= '0;
      step_q    <= '0;
      trig_q    <= 1'b0;
      freq_sh   <= freq_in;
      wait_sh   <= bus.i_wait_cnt;
      offset_sh <= bus.i_err_offset;
      pol_sh    <= bus.i_polarity;
      gain_sh   <= gain_in;
    end else begin
      trig_q <= 1'b0;
      pend   <= 1'b0;
      if (bus.i_adc_valid) cnt <= last ? 32'd0 : cnt + 32'd1;

      // fresh marks a period with no sample yet; only such a period may start integrating.
      if (period_end) begin
        fresh     <= 1'b1;
        freq_sh   <= freq_in;
        wait_sh   <= bus.i_wait_cnt;
        offset_sh <= bus.i_err_offset;
        pol_sh    <= bus.i_polarity;
        gain_sh   <= gain_in;
      end else if (bus.i_adc_valid) begin
        fresh <= 1'b0;
      end

      if (!fb_on) begin
        active   <= 1'b0;
        acc_pos  <= '0;
        acc_neg  <= '0;
        sat_flag <= 1'b0;
        sat_hold <= 1'b0;
        err_q    <= '0;
        step_q   <= '0;
      end else begin
        if (bus.i_adc_valid) active <= run;
        if (period_end) begin
          acc_pos  <= '0;
          acc_neg  <= '0;
          sat_flag <= 1'b0;
          if (run) begin
            err_q    <= err_calc;
            pend     <= 1'b1;
            pend_sat <= sat_flag | add_sat;
            gain_p   <= gain_sh;
          end
        end else if (add) begin
          if (state == S_POS) acc_pos <= sum_sat;
          else                acc_neg <= sum_sat;
          if (add_sat) sat_flag <= 1'b1;
        end
        if (pend) begin
          step_q   <= err_q >>> gain_p;
          trig_q   <= 1'b1;
          sat_hold <= pend_sat;
        end
      end
    end
  end

  assign bus.o_mod_sign = mod_sign;
  assign bus.o_err      = err_q;
  assign bus.o_step     = step_q;
  assign bus.o_trig     = trig_q;
  assign bus.o_status   = status;
endmodule
`default_nettype wire

// File: tb/tb_fog_err_demod.sv
`default_nettype none
// tb_fog_err_demod: randomized periods predicted by a period-level model; a monitor
// pops the expected trigger results and compares them as the DUT pulses o_trig.
module tb_fog_err_demod;
  localparam int ADC_WIDTH = 14;
  localparam int ERR_WIDTH = 16;
  localparam longint EMAX = (64'sd1 <<< (ERR_WIDTH-1)) - 1;
  localparam longint EMIN = -(64'sd1 <<< (ERR_WIDTH-1));

  typedef struct {
    int     cyc;
    longint err;
    longint step;
    int     status;
  } exp_t;

  typedef struct {
    int freq;
    int wait_c;
    int offset;
    bit pol;
    int gain;
  } cfg_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;
  cfg_t cur, nxt;

  fog_err_demod_if #(.ADC_WIDTH(ADC_WIDTH), .ERR_WIDTH(ERR_WIDTH)) bus();

  fog_err_demod #(.ADC_WIDTH(ADC_WIDTH), .ERR_WIDTH(ERR_WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint satw(input longint x);
    if (x > EMAX) return EMAX;
    if (x < EMIN) return EMIN;
    return x;
  endfunction

  // Reference: integrate each half-period from the sample list, then form the error.
  function automatic exp_t predict(input cfg_t c, input int s[$]);
    int     f;
    int     g;
    longint acc[2];
    longint d;
    bit     sat;
    exp_t   e;
    f = (c.freq < 2) ? 2 : c.freq;
    g = (c.gain > 31) ? 31 : c.gain;
    acc[0] = 0;
    acc[1] = 0;
    sat = 1'b0;
    for (int i = 0; i < 2*f; i++) begin
      if ((i % f) >= c.wait_c) begin
        longint t;
        t = acc[i/f] + longint'(s[i]);
        if (t != satw(t)) sat = 1'b1;
        acc[i/f] = satw(t);
      end
    end
    d = satw(acc[0] - acc[1] - longint'(c.offset));
    if (c.pol) d = satw(-d);
    e.cyc    = 0;
    e.err    = d;
    e.step   = d >>> g;
    e.status = sat ? 3 : 1;
    return e;
  endfunction

  task automatic apply_inputs(input cfg_t c);
    bus.i_freq       = 32'(c.freq);
    bus.i_wait_cnt   = 32'(c.wait_c);
    bus.i_err_offset = 32'(c.offset);
    bus.i_polarity   = c.pol;
    bus.i_gain_sel   = 32'(c.gain);
  endtask

  task automatic idle(input int n);
    bus.i_adc_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // smode: 0 random samples, 1 +100/-100, 2 constant +8191.
  task automatic run_period(input bit report, input int smode, input int gap_pct,
                            input bit do_rst, input int close_at);
    int   f;
    int   rst_at;
    int   s[$];
    exp_t e;
    f = (cur.freq < 2) ? 2 : cur.freq;
    rst_at = do_rst ? (f + f/2) : -1;
    for (int i = 0; i < 2*f; i++) begin
      case (smode)
        0:       s.push_back(int'($urandom_range(0, 16382)) - 8191);
        1:       s.push_back((i < f) ? 100 : -100);
        default: s.push_back(8191);
      endcase
    end
    e = predict(cur, s);
    for (int i = 0; i < 2*f; i++) begin
      while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        bus.i_adc_valid = 1'b0;
        @(negedge clk);
      end
      if (i == rst_at) begin
        bus.i_adc_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mod_sign", bus.o_mod_sign, 1);
        chk("rst_err", bus.o_err, 0);
        chk("rst_step", bus.o_step, 0);
        chk("rst_trig", bus.o_trig, 0);
        chk("rst_status", bus.o_status, 0);
        rst_n = 1'b1;
        cur = nxt;
        return;
      end
      if (i == close_at) bus.i_fb_ON = 32'd1;
      if (i == 0) apply_inputs(nxt);
      chk("mod_sign", bus.o_mod_sign, (i < f) ? 1 : 0);
      bus.i_adc_valid = 1'b1;
      bus.i_adc = ADC_WIDTH'(s[i]);
      if (report && i == 2*f-1) begin
        e.cyc = cyc + 2;
        q.push_back(e);
      end
      @(negedge clk);
    end
    bus.i_adc_valid = 1'b0;
    cur = nxt;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && cyc > q[0].cyc) begin
      chk("trig_missing", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (rst_n && bus.o_trig) begin
      if (q.size() == 0) begin
        chk("trig_unexpected", bus.o_trig, 0);
      end else begin
        mon_e = q.pop_front();
        chk("trig_cycle", cyc, mon_e.cyc);
        chk("err", bus.o_err, mon_e.err);
        chk("step", bus.o_step, mon_e.step);
        chk("status", bus.o_status, mon_e.status);
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_adc_valid = 1'b0;
    bus.i_adc = '0;
    bus.i_fb_ON = 32'd1;
    nxt = '{freq: 4, wait_c: 1, offset: 0, pol: 1'b0, gain: 0};
    apply_inputs(nxt);
    cur = nxt;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_mod_sign", bus.o_mod_sign, 1);
    chk("reset_err", bus.o_err, 0);
    chk("reset_step", bus.o_step, 0);
    chk("reset_trig", bus.o_trig, 0);
    chk("reset_status", bus.o_status, 0);
    rst_n = 1'b1;

    repeat (3) run_period(1, 1, 0, 1'b0, -1);
    idle(3);
    chk("basic_err", bus.o_err, 600);
    chk("basic_step", bus.o_step, 600);

    nxt = '{freq: 4, wait_c: 1, offset: 40, pol: 1'b1, gain: 2};
    repeat (3) run_period(1, 1, 0, 1'b0, -1);
    idle(3);
    chk("neg_gain_err", bus.o_err, -560);
    chk("neg_gain_step", bus.o_step, -140);

    nxt = '{freq: 4, wait_c: 5, offset: 0, pol: 1'b0, gain: 0};
    repeat (3) run_period(1, 1, 0, 1'b0, -1);
    idle(3);
    chk("wait_ge_freq_err", bus.o_err, 0);

    nxt = '{freq: 16, wait_c: 0, offset: 0, pol: 1'b0, gain: 0};
    repeat (2) run_period(1, 2, 0, 1'b0, -1);
    idle(3);
    chk("sat_status_held", bus.o_status, 3);

    idle(4);
    bus.i_fb_ON = 32'd0;
    nxt = '{freq: 4, wait_c: 1, offset: 0, pol: 1'b0, gain: 0};
    repeat (3) run_period(0, 0, 25, 1'b0, -1);
    chk("open_err", bus.o_err, 0);
    chk("open_step", bus.o_step, 0);
    chk("open_status", bus.o_status, 0);
    run_period(0, 0, 0, 1'b0, 2);
    repeat (2) run_period(1, 1, 0, 1'b0, -1);
    idle(3);
    chk("closed_err", bus.o_err, 600);

    idle(4);
    run_period(0, 0, 20, 1'b1, -1);
    repeat (2) run_period(1, 0, 20, 1'b0, -1);

    for (int p = 0; p < 40; p++) begin
      nxt.freq   = int'($urandom_range(0, 7));
      nxt.wait_c = int'($urandom_range(0, 8));
      nxt.offset = int'($urandom_range(0, 4000)) - 2000;
      if ($urandom_range(0, 9) == 0) nxt.offset = ($urandom_range(0, 1) == 1) ? 40000 : -40000;
      nxt.pol    = 1'($urandom_range(0, 1));
      nxt.gain   = int'($urandom_range(0, 40));
      run_period(1, 0, int'($urandom_range(0, 40)), 1'b0, -1);
    end

    idle(10);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fog_err_demod.md
Name: fog_err_demod

Overview:
- Closed-loop FOG error demodulator: the producer of the step/trigger pair consumed by the phase ramp generator.
- Generates the square-wave modulation state and integrates ADC samples separately over the positive and negative half-periods.
- Once per modulation period, outputs the demodulated rotation error, scaled by a gain shift, as a signed step with a one-cycle trigger.

Parameters:
ADC_WIDTH, 14, width of signed ADC sample input
ERR_WIDTH, 32, width of accumulators, error and step outputs

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset; synchronous, active-low
i_adc_valid  in  1  one-cycle strobe, i_adc valid this cycle
i_adc  in  ADC_WIDTH  signed ADC sample
i_freq  in  32  half-period length in valid samples
i_wait_cnt  in  32  samples ignored after each modulation edge
i_err_offset  in  32  signed error offset subtracted per period
i_polarity  in  1  1 = negate error
i_fb_ON  in  32  0 = loop open
i_gain_sel  in  32  arithmetic right shift applied to error
o_mod_sign  out  1  modulation state, 1 = positive half
o_err  out  ERR_WIDTH  signed demodulated error of last period
o_step  out  ERR_WIDTH  signed scaled step
o_trig  out  1  one-cycle pulse, o_step updated
o_status  out  2  0 idle/open, 1 positive half, 2 negative half, 3 saturated last period

Behaviour:
- Reset (i_rst_n low at a clock edge): o_mod_sign=1, o_err=0, o_step=0, o_trig=0, o_status=0. Sample counter, both accumulators and the saturation flag clear.
- Reset mid-period discards the partial period; the first period after reset starts on the positive half.
- Config latch:
  - i_freq, i_wait_cnt, i_err_offset, i_polarity and i_gain_sel are registered into shadow copies only at period start: after reset and on the cycle the negative half ends.
  - Mid-period config changes take effect from the next period.
- Clamps applied at latch: freq<2 -> 2; gain_sel>31 -> 31.
- Half-period counter:
  - Increments only on i_adc_valid, range 0..freq-1.
  - On a valid sample with count==freq-1: counter returns to 0 and o_mod_sign toggles on the next edge.
- Accumulation:
  - A valid sample with count>=wait_cnt is sign-extended and added to acc_pos (o_mod_sign=1) or acc_neg (o_mod_sign=0).
  - Each add saturates to ERR_WIDTH signed range; a saturation sets the saturation flag for that period.
  - wait_cnt>=freq -> no samples accumulated and both accumulators stay 0.
- Period end: a valid sample with count==freq-1 while o_mod_sign=0 (cycle T).
  - T+1: o_err = sat(acc_pos - acc_neg - offset), negated (saturating) if polarity=1. Both accumulators clear; the sample at T is included in the error.
  - T+2: o_step = o_err >>> gain_sel (arithmetic); o_trig high for exactly this one cycle; o_status=3 if the saturation flag is set, after which the flag clears.
- A valid sample arriving at T+1 starts the next period normally; the pipeline must not drop or double-count it.
- Loop open (i_fb_ON==0, registered one cycle):
  - Modulation counter and o_mod_sign keep running.
  - Accumulators held at 0; o_err, o_step = 0; o_trig never pulses; o_status=0.
- Loop closing (i_fb_ON 0->nonzero): accumulation starts at the next period start, so a partial first period is never reported.
- o_status while running: 1/2 follows o_mod_sign, except 3 is held from a saturated trigger until the next trigger.
- i_adc_valid may be held high every cycle; back-to-back samples must be fully supported.

Test Plan:
- freq=4, wait=1, offset=0, polarity=0, gain=0, fb_ON=1, adc=+100 on positive half, -100 on negative half, valid every cycle -> o_mod_sign toggles every 4 samples; o_err=600, o_step=600, o_trig one cycle, 2 cycles after the 8th sample; repeats every 8 samples.
- Same stimulus with gain=2, offset=40, polarity=1 -> o_err=-560, o_step=-140.
- wait=5, freq=4 -> o_err=0, o_step=0, o_trig still pulses each period.
- fb_ON=0 for 3 periods, then 1 asserted mid-period -> no o_trig until the first full period completes; o_mod_sign uninterrupted.
- ADC_WIDTH=14, ERR_WIDTH=16, adc=+8191 constant, freq=16, wait=0 -> acc_pos saturates at 32767; o_status=3 on that trigger.
- i_rst_n low for 1 cycle mid-negative-half -> all outputs zero, o_mod_sign=1 next cycle; next trigger reflects only post-reset samples.
